// File: rtl/timeset_rx_pkg.sv
// Shared constants, state encodings and helpers for the serial time-set receiver.
// TIMESET_RX_PARITY_EN (when defined) adds an even-parity bit in uart_rxbit.
package timeset_rx_pkg;

   localparam logic [7:0] ASCII_T     = 8'h54;
   localparam logic [7:0] ASCII_CR    = 8'h0D;
   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_9     = 8'h39;
   localparam logic [7:0] MAX_HOUR    = 8'd23;
   localparam logic [7:0] MAX_MIN_SEC = 8'd59;
   localparam logic [2:0] LAST_DIGIT  = 3'd5;

   typedef enum logic [1:0] {
      B_IDLE  = 2'd0,
      B_START = 2'd1,
      B_DATA  = 2'd2,
      B_STOP  = 2'd3
   } bit_state_e;

   typedef enum logic [1:0] {
      P_IDLE  = 2'd0,
      P_DIGIT = 2'd1,
      P_CR    = 2'd2
   } parse_state_e;

   typedef struct packed {
      logic [1:0] hourh;
      logic [3:0] hourl;
      logic [2:0] minh;
      logic [3:0] minl;
      logic [2:0] sech;
      logic [3:0] secl;
   } time_t;

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= ASCII_0) && (b <= ASCII_9);
   endfunction

   function automatic logic [7:0] two_digit(input logic [3:0] hi, input logic [3:0] lo);
      return 8'(hi) * 8'd10 + 8'(lo);
   endfunction

   // Digits are staged in arrival order: index 0 is the hour tens digit.
   function automatic logic time_ok(input logic [5:0][3:0] d);
      return (two_digit(d[0], d[1]) <= MAX_HOUR) &&
             (two_digit(d[2], d[3]) <= MAX_MIN_SEC) &&
             (two_digit(d[4], d[5]) <= MAX_MIN_SEC);
   endfunction

endpackage

// File: rtl/uart_rxbit.sv
// Bit-level UART receiver: synchronizer, mid-bit sampling, byte strobe / frame error.
// TIMESET_RX_PARITY_EN adds an even-parity bit between data bit 7 and stop.
module uart_rxbit
   import timeset_rx_pkg::*;
#(
   parameter int unsigned DIV = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] rx_byte,
   output logic       rx_stb,
   output logic       rx_err
);

   localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
`ifdef TIMESET_RX_PARITY_EN
   localparam logic [3:0] LAST_BIT = 4'd8;
`else
   localparam logic [3:0] LAST_BIT = 4'd7;
`endif

   logic             sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   bit_state_e       bst_q, bst_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       idx_q, idx_d;
   logic [7:0]       shr_q, shr_d;
   logic             stb_q, stb_d, err_q, err_d;
   logic             tick;
`ifdef TIMESET_RX_PARITY_EN
   logic             par_q, par_d;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         bst_q   <= B_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shr_q   <= '0;
         stb_q   <= 1'b0;
         err_q   <= 1'b0;
`ifdef TIMESET_RX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
         bst_q   <= bst_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shr_q   <= shr_d;
         stb_q   <= stb_d;
         err_q   <= err_d;
`ifdef TIMESET_RX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      sync1_d = rxd;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      bst_d   = bst_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shr_d   = shr_q;
      stb_d   = 1'b0;
      err_d   = 1'b0;
`ifdef TIMESET_RX_PARITY_EN
      par_d   = par_q;
`endif
      tick    = (cnt_q == '0);
      // Sample point reached: reload a full bit period for the next sample.
      if (bst_q != B_IDLE) begin
         cnt_d = tick ? CNT_W'(DIV - 1) : cnt_q - CNT_W'(1);
      end
      case (bst_q)
         B_IDLE: begin
            if (prev_q && !sync2_q) begin
               bst_d = B_START;
               cnt_d = CNT_W'(DIV / 2 - 1);
            end
         end
         B_START: begin
            if (tick) begin
               bst_d = sync2_q ? B_IDLE : B_DATA;
               idx_d = '0;
            end
         end
         B_DATA: begin
            if (tick) begin
`ifdef TIMESET_RX_PARITY_EN
               if (idx_q == LAST_BIT) par_d = sync2_q;
               else shr_d = {sync2_q, shr_q[7:1]};
`else
               shr_d = {sync2_q, shr_q[7:1]};
`endif
               if (idx_q == LAST_BIT) bst_d = B_STOP;
               else idx_d = idx_q + 4'd1;
            end
         end
         B_STOP: begin
            if (tick) begin
               bst_d = B_IDLE;
`ifdef TIMESET_RX_PARITY_EN
               stb_d = sync2_q && (par_q == ^shr_q);
`else
               stb_d = sync2_q;
`endif
               err_d = !stb_d;
            end
         end
         default: bst_d = B_IDLE;
      endcase
   end

   assign rx_byte = shr_q;
   assign rx_stb  = stb_q;
   assign rx_err  = err_q;

endmodule

// File: rtl/timeset_rx.sv
// Serial time-set receiver: parses "T" HHMMSS CR frames into validated BCD time outputs.
// TIMESET_RX_PARITY_EN selects the even-parity byte format in uart_rxbit.
module timeset_rx
   import timeset_rx_pkg::*;
#(
   parameter int unsigned CLK_HZ = 50000000,
   parameter int unsigned BAUD   = 115200
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RXD,
   output logic       LOAD,
   output logic [1:0] HOURH,
   output logic [3:0] HOURL,
   output logic [2:0] MINH,
   output logic [3:0] MINL,
   output logic [2:0] SECH,
   output logic [3:0] SECL,
   output logic       ERR,
   output logic       BUSY
);

   localparam int unsigned DIV = CLK_HZ / BAUD;

   logic [7:0]      rx_byte;
   logic            rx_stb, rx_err;
   parse_state_e    pst_q, pst_d;
   logic [2:0]      didx_q, didx_d;
   logic [5:0][3:0] stg_q, stg_d;
   time_t           tim_q, tim_d;
   logic            load_q, load_d, err_q, err_d, busy_q, busy_d;

   uart_rxbit #(.DIV(DIV)) u_rxbit (
      .clk     (CLK),
      .rst     (RST),
      .rxd     (RXD),
      .rx_byte (rx_byte),
      .rx_stb  (rx_stb),
      .rx_err  (rx_err)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pst_q  <= P_IDLE;
         didx_q <= '0;
         stg_q  <= '0;
         tim_q  <= '0;
         load_q <= 1'b0;
         err_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         pst_q  <= pst_d;
         didx_q <= didx_d;
         stg_q  <= stg_d;
         tim_q  <= tim_d;
         load_q <= load_d;
         err_q  <= err_d;
         busy_q <= busy_d;
      end
   end

   always_comb begin
      pst_d  = pst_q;
      didx_d = didx_q;
      stg_d  = stg_q;
      tim_d  = tim_q;
      load_d = 1'b0;
      err_d  = 1'b0;
      if (rx_err) begin
         err_d = 1'b1;
         pst_d = P_IDLE;
      end else if (rx_stb) begin
         // A 'T' always (re)starts a frame, whatever the parser was doing.
         if (rx_byte == ASCII_T) begin
            pst_d  = P_DIGIT;
            didx_d = '0;
         end else begin
            case (pst_q)
               P_IDLE: pst_d = P_IDLE;
               P_DIGIT: begin
                  if (is_digit(rx_byte)) begin
                     stg_d[didx_q] = rx_byte[3:0];
                     if (didx_q == LAST_DIGIT) pst_d = P_CR;
                     else didx_d = didx_q + 3'd1;
                  end else begin
                     err_d = 1'b1;
                     pst_d = P_IDLE;
                  end
               end
               P_CR: begin
                  pst_d = P_IDLE;
                  if ((rx_byte == ASCII_CR) && time_ok(stg_q)) begin
                     load_d      = 1'b1;
                     tim_d.hourh = stg_q[0][1:0];
                     tim_d.hourl = stg_q[1];
                     tim_d.minh  = stg_q[2][2:0];
                     tim_d.minl  = stg_q[3];
                     tim_d.sech  = stg_q[4][2:0];
                     tim_d.secl  = stg_q[5];
                  end else begin
                     err_d = 1'b1;
                  end
               end
               default: pst_d = P_IDLE;
            endcase
         end
      end
      busy_d = (pst_d != P_IDLE);
   end

   assign LOAD  = load_q;
   assign ERR   = err_q;
   assign BUSY  = busy_q;
   assign HOURH = tim_q.hourh;
   assign HOURL = tim_q.hourl;
   assign MINH  = tim_q.minh;
   assign MINL  = tim_q.minl;
   assign SECH  = tim_q.sech;
   assign SECL  = tim_q.secl;

endmodule

// File: doc/timeset_rx.md
TIMESET_RX -- requirements
Module: timeset_rx

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 CLK  input  1  system clock; all state rising-edge triggered.
REQ-004 RST  input  1  asynchronous, active-high reset.
REQ-005 RXD  input  1  serial line, idle high, 8 data bits LSB first, 1 stop bit.
REQ-006 LOAD  output  1  one-cycle pulse; time fields below valid and new.
REQ-007 HOURH  output  2  hour tens digit, 0-2.
REQ-008 HOURL  output  4  hour units digit, 0-9.
REQ-009 MINH  output  3  minute tens digit, 0-5.
REQ-010 MINL  output  4  minute units digit, 0-9.
REQ-011 SECH  output  3  second tens digit, 0-5.
REQ-012 SECL  output  4  second units digit, 0-9.
REQ-013 ERR  output  1  one-cycle pulse on rejected byte or frame.
REQ-014 BUSY  output  1  high while a frame is partially received.

Function
REQ-015 RXD SHALL pass a 2-flop synchronizer before any use.
REQ-016 Bit period SHALL be DIV = CLK_HZ/BAUD (integer division); 434 at defaults.
REQ-017 Falling edge in bit IDLE SHALL start a DIV/2 count; start bit resampled there, if high return to IDLE with no ERR.
REQ-018 Each data bit and the stop bit SHALL be sampled DIV cycles after the previous sample.
REQ-019 Stop bit sampled low SHALL discard the byte, pulse ERR, return parser to P_IDLE.
REQ-020 Bit FSM states: B_IDLE, B_START, B_DATA (bit index 0-7), B_STOP; byte strobe one cycle after stop sample.
REQ-021 Frame format: 'T' (0x54), six ASCII digits H H M M S S, CR (0x0D).
REQ-022 Parser states: P_IDLE, P_DIGIT (index 0-5), P_CR; BUSY = not P_IDLE.
REQ-023 P_IDLE: 'T' -> P_DIGIT index 0; any other byte ignored, no ERR.
REQ-024 P_DIGIT: byte 0x30-0x39 stored, index+1, after index 5 -> P_CR; non-digit -> ERR, P_IDLE.
REQ-025 'T' received in P_DIGIT or P_CR SHALL restart at P_DIGIT index 0, no ERR.
REQ-026 P_CR: CR with HH<=23, MM<=59, SS<=59 -> LOAD pulse the cycle after the byte strobe; out-of-range -> ERR; any other byte -> ERR; all return to P_IDLE.
REQ-027 Outputs HOURH..SECL SHALL update only together with LOAD and hold until the next LOAD.
REQ-028 LOAD and ERR SHALL never be high in the same cycle.
REQ-029 Digit staging registers SHALL be separate from output registers; rejected frames leave outputs unchanged.

Reset
REQ-030 RST high SHALL immediately force B_IDLE, P_IDLE, LOAD=0, ERR=0, BUSY=0, all time outputs 0.
REQ-031 RST mid-byte or mid-frame SHALL discard partial data; no LOAD or ERR follows release.
REQ-032 After release, the first falling edge on synchronized RXD SHALL be treated as a start bit.

Configuration
REQ-033 Macro TIMESET_RX_PARITY_EN defined: an even-parity bit follows data bit 7 and precedes stop; mismatch -> byte discarded, ERR, P_IDLE.
REQ-034 Macro undefined: no parity bit; frame is 10 bits; no parity logic synthesized.

Structure
REQ-035 Shared package SHALL hold ASCII constants (0x54, 0x0D, 0x30, 0x39), range limits (23, 59) and bit/parser state encodings.
REQ-036 Bit-level receiver SHALL be one sub-module uart_rxbit (outputs byte, byte strobe, framing/parity error); parser in timeset_rx.

Verification
REQ-037 Send "T123456\r" at 115200 -> single LOAD; HOURH=1 HOURL=2 MINH=3 MINL=4 SECH=5 SECL=6; BUSY low after.
REQ-038 Send "T236000\r" -> ERR pulse, no LOAD, outputs keep prior values.
REQ-039 Send "T12T235959\r" -> LOAD with 23:59:59, no ERR.
REQ-040 Send "T12A456\r" -> ERR on 'A', later bytes ignored, no LOAD; then "T000000\r" -> LOAD 00:00:00.
REQ-041 Byte with stop bit forced low mid-frame -> ERR, P_IDLE; 1-cycle 0 glitch on RXD -> no byte, no ERR.
REQ-042 Assert RST during digit 3 of a valid frame -> all outputs 0 at once; no LOAD; next full frame loads correctly.
